// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: lock-qualified staged reset generator behind the PLL.
// Synchronises the raw PLL lock flag and waits for it to stay high for
// STABLE_CYCLES cycles. It then releases N_CHAN active-low domain resets in
// order, STAGE_GAP cycles apart. Any lock loss after the first release
// re-asserts every domain reset on one edge and is counted for diagnostics.
//
// Ports:
//   clk              PLL global output clock
//   reset_n          asynchronous active-low reset
//   pll_locked       raw PLL LOCK, asynchronous to clk
//   clear_sticky     synchronous clear of lock_lost_sticky (a same-edge loss wins)
//   rst_out_n        active-low domain resets; bit 0 is released first
//   ready            all channels released and lock still held
//   lock_lost_sticky set by any counted lock loss
//   lock_lost_cnt    saturating count of lock-loss events
module pll_lock_sequencer #(
    parameter int unsigned N_CHAN        = 4,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_GAP     = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_locked,
    input  logic              clear_sticky,
    output logic [N_CHAN-1:0] rst_out_n,
    output logic              ready,
    output logic              lock_lost_sticky,
    output logic [CNT_W-1:0]  lock_lost_cnt
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned GAP_W  = $clog2(STAGE_GAP + 1);
    localparam int unsigned CHAN_W = $clog2(N_CHAN + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                meta_q;
    logic                lk_s_q;
    logic [STAB_W-1:0]   stab_q, stab_d, stab_nxt;
    logic [GAP_W-1:0]    gap_q, gap_d, gap_nxt;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic [N_CHAN-1:0]   rst_q, rst_d, chan_mask;
    logic                ready_q, ready_d;
    logic                sticky_q, sticky_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                go_release;
    logic                lost;

    // Two-flop synchroniser for the raw lock flag; only lk_s_q is used below.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            lk_s_q <= 1'b0;
        end else begin
            meta_q <= pll_locked;
            lk_s_q <= meta_q;
        end
    end

    // One-hot select of the channel released next (chan_q = channels already released).
    always_comb begin
        chan_mask = '0;
        for (int unsigned i = 0; i < N_CHAN; i++) begin
            if (CHAN_W'(i) == chan_q) begin
                chan_mask[i] = 1'b1;
            end
        end
    end

    // Stable count reaching STABLE_CYCLES on an edge is what releases channel 0.
    // WAIT_LOCK loads 1, so this also covers STABLE_CYCLES == 1.
    assign stab_nxt = (state_q == WAIT_LOCK) ? STAB_W'(1) : stab_q + STAB_W'(1);
    assign gap_nxt  = gap_q + GAP_W'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        stab_d     = stab_q;
        gap_d      = gap_q;
        chan_d     = chan_q;
        rst_d      = rst_q;
        ready_d    = ready_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        go_release = 1'b0;
        lost       = 1'b0;

        if (clear_sticky) begin
            sticky_d = 1'b0;
        end

        case (state_q)
            WAIT_LOCK: begin
                rst_d   = '0;
                ready_d = 1'b0;
                gap_d   = '0;
                chan_d  = '0;
                stab_d  = '0;
                if (lk_s_q) begin
                    if (stab_nxt == STAB_W'(STABLE_CYCLES)) begin
                        go_release = 1'b1;
                    end else begin
                        state_d = STABILIZE;
                        stab_d  = stab_nxt;
                    end
                end
            end

            // A drop here only restarts the wait; nothing has been released yet.
            STABILIZE: begin
                if (!lk_s_q) begin
                    state_d = WAIT_LOCK;
                    stab_d  = '0;
                end else if (stab_nxt == STAB_W'(STABLE_CYCLES)) begin
                    go_release = 1'b1;
                end else begin
                    stab_d = stab_nxt;
                end
            end

            // Loss takes priority over a stage release landing on the same edge.
            RELEASE: begin
                if (!lk_s_q) begin
                    lost = 1'b1;
                end else if (gap_nxt == GAP_W'(STAGE_GAP)) begin
                    gap_d  = '0;
                    rst_d  = rst_q | chan_mask;
                    chan_d = chan_q + CHAN_W'(1);
                    if (chan_q == CHAN_W'(N_CHAN - 1)) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_nxt;
                end
            end

            RUN: begin
                if (!lk_s_q) begin
                    lost = 1'b1;
                end else begin
                    rst_d   = '1;
                    ready_d = 1'b1;
                end
            end

            default: begin
                state_d = WAIT_LOCK;
                rst_d   = '0;
                ready_d = 1'b0;
            end
        endcase

        // First release: channel 0 goes on this edge; a single channel goes straight to RUN.
        if (go_release) begin
            stab_d = '0;
            gap_d  = '0;
            chan_d = CHAN_W'(1);
            rst_d  = N_CHAN'(1);
            if (N_CHAN == 1) begin
                state_d = RUN;
                ready_d = 1'b1;
            end else begin
                state_d = RELEASE;
                ready_d = 1'b0;
            end
        end

        // Counted loss: every domain asserts on one edge; sticky set beats clear.
        if (lost) begin
            state_d  = WAIT_LOCK;
            rst_d    = '0;
            ready_d  = 1'b0;
            stab_d   = '0;
            gap_d    = '0;
            chan_d   = '0;
            sticky_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WAIT_LOCK;
            stab_q   <= '0;
            gap_q    <= '0;
            chan_q   <= '0;
            rst_q    <= '0;
            ready_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            stab_q   <= stab_d;
            gap_q    <= gap_d;
            chan_q   <= chan_d;
            rst_q    <= rst_d;
            ready_q  <= ready_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rst_out_n        = rst_q;
    assign ready            = ready_q;
    assign lock_lost_sticky = sticky_q;
    assign lock_lost_cnt    = cnt_q;

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Lock-qualified, staged reset generator that sits directly behind the PLL wrapper. It runs on the PLL's global output clock.
- Filters the raw PLL lock flag and waits for it to stay stable.
- Releases N_CHAN downstream reset domains in a fixed, spaced order.
- Re-asserts every domain reset on loss of lock, and counts lock-loss events for diagnostics.

Parameters:
- N_CHAN, 4: number of sequenced reset outputs; legal range 1..16.
- STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before the first release; must be >= 1.
- STAGE_GAP, 16: cycles between release of channel i and channel i+1; must be >= 1.
- CNT_W, 8: width of the lock-loss event counter.

Ports:
- clk  input  1  PLL global output clock.
- reset_n  input  1  asynchronous, active-low reset.
- pll_locked  input  1  raw PLL LOCK; asynchronous to clk.
- clear_sticky  input  1  synchronous; clears lock_lost_sticky.
- rst_out_n  output  N_CHAN  active-low domain resets; bit 0 is released first.
- ready  output  1  high when all channels are released and lock is held.
- lock_lost_sticky  output  1  set on any counted lock loss.
- lock_lost_cnt  output  CNT_W  saturating count of lock-loss events.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Outputs while reset_n is low (immediately, asynchronously):
  - rst_out_n = all 0, ready = 0, lock_lost_sticky = 0, lock_lost_cnt = 0.
  - Synchroniser flops = 0, stable counter = 0, state = WAIT_LOCK.
- Synchroniser: 2-flop chain on pll_locked produces lk_s. Only lk_s is used internally.
- FSM states: WAIT_LOCK, STABILIZE, RELEASE, RUN. All outputs are registered.
- WAIT_LOCK:
  - rst_out_n = 0, ready = 0.
  - lk_s = 1 → STABILIZE, with stable counter loaded to 1.
- STABILIZE:
  - lk_s = 1: counter increments.
  - When the counter reaches STABLE_CYCLES → RELEASE; rst_out_n[0] = 1 and the gap counter is cleared on the same edge.
  - lk_s = 0: → WAIT_LOCK, counter cleared, no lock-loss count.
- RELEASE:
  - Gap counter runs. Every STAGE_GAP cycles the next channel is released (bit i+1 set).
  - The edge that sets bit N_CHAN-1 also moves the FSM to RUN and sets ready = 1.
  - N_CHAN = 1: STABILIZE goes directly to RUN, setting rst_out_n[0] and ready on the same edge.
- RUN: ready = 1, all rst_out_n = 1.
- Lock loss (lk_s = 0 while in RELEASE or RUN):
  - On the next edge: rst_out_n = all 0, ready = 0, state = WAIT_LOCK.
  - lock_lost_cnt increments, saturating at 2^CNT_W-1; lock_lost_sticky = 1.
  - All channels assert on the same edge; there is no staged re-assertion.
- Release timing: if pll_locked is stable high from edge E0 (its first sampled-high edge):
  - lk_s = 1 at E0+1.
  - rst_out_n[0] rises at edge E0+1+STABLE_CYCLES.
  - rst_out_n[i] rises at that edge + i*STAGE_GAP.
  - ready rises with rst_out_n[N_CHAN-1].
- Lock loss latency: a pll_locked fall sampled at edge F gives rst_out_n = 0 at edge F+2.
- clear_sticky: clears lock_lost_sticky on the next edge. If a lock loss is counted on the same edge, set wins (sticky stays 1). clear_sticky does not affect lock_lost_cnt.
- Glitches: a pll_locked low pulse shorter than one clk period may or may not be captured. A captured pulse restarts STABILIZE, or counts as a loss in RELEASE/RUN.
- Mid-operation reset: reset_n low at any point returns everything to reset values within the same cycle (asynchronously). Release restarts from WAIT_LOCK after reset_n rises.
- Widths:
  - Stable counter: clog2(STABLE_CYCLES+1) bits.
  - Gap counter: clog2(STAGE_GAP+1) bits.
  - Channel index: clog2(N_CHAN+1) bits.
  - No counter wraps; all counters either saturate or are cleared.

Test Plan (N_CHAN=3, STABLE_CYCLES=8, STAGE_GAP=4, CNT_W=2):
- Clean lock:
  - Stimulus: reset_n released, pll_locked held high from edge 10.
  - Required: rst_out_n[0] rises at edge 19, [1] at 23, [2] at 27; ready=1 at 27; lock_lost_cnt=0.
- Lock flaps during STABILIZE:
  - Stimulus: pll_locked high at edge 10, low at edge 14 for 2 cycles, then high at edge 16 onward.
  - Required: no rst_out_n release before edge 25; rst_out_n[0] rises at 25; cnt=0; sticky=0.
- Loss in RUN:
  - Stimulus: after ready, pll_locked low sampled at edge F.
  - Required: rst_out_n=3'b000 and ready=0 at F+2; cnt=1; sticky=1.
  - Then relock → full staged release repeats with the same spacing.
- Loss mid-RELEASE:
  - Stimulus: pll_locked drops when only rst_out_n[0] is high.
  - Required: all channels low 2 edges later; cnt increments; ready never asserts.
- Counter saturation and sticky:
  - Stimulus: 5 counted losses.
  - Required: lock_lost_cnt=3.
  - clear_sticky asserted alone → sticky=0 next edge, cnt stays 3.
  - clear_sticky on the same edge as a counted loss → sticky=1.
- Async reset:
  - Stimulus: assert reset_n mid-RELEASE, between clock edges.
  - Required: all outputs return to reset values before the next edge.
  - On reset_n release with pll_locked high, timing repeats as in the clean-lock case.
